// File: rtl/crc_nrzi_pkg.sv
`default_nettype none
// ============================================================================
// crc_nrzi_pkg : shared types, default frame constants and CRC step function
// Revision     : 1.0
// ============================================================================
package crc_nrzi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } rx_state_e;

    localparam int          DATA_W_DEF   = 32;
    localparam int          CRC_W_DEF    = 16;
    localparam logic [15:0] POLY_DEF     = 16'h8005;
    localparam logic [15:0] CRC_INIT_DEF = 16'h0000;
    localparam int          CRC_MAX      = 32;

    // One LFSR step for any width up to CRC_MAX; bits above width are cleared.
    function automatic logic [CRC_MAX-1:0] crc_step(
        input logic [CRC_MAX-1:0] crc,
        input logic               b,
        input logic [CRC_MAX-1:0] poly,
        input int                 width
    );
        logic [CRC_MAX-1:0] top;
        logic [CRC_MAX-1:0] nxt;
        logic [CRC_MAX-1:0] mask;
        logic               fb;
        top  = crc >> (width - 1);
        fb   = top[0] ^ b;
        nxt  = (crc << 1) ^ (fb ? poly : '0);
        mask = CRC_MAX'((64'd1 << width) - 64'd1);
        return nxt & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nrzi_dec.sv
`default_nettype none
// ============================================================================
// nrzi_dec : NRZI to NRZ decoder, a line transition decodes as 1
// Revision : 1.0
// ============================================================================
module nrzi_dec (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic en_i,
    input  logic y_i,
    output logic d_o
);

    logic r_prev_line;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_prev_line <= 1'b0;
        end else if (en_i) begin
            r_prev_line <= y_i;
        end
    end

    assign d_o = y_i ^ r_prev_line;

endmodule
`default_nettype wire

// File: rtl/nrzi_crc_rx.sv
`default_nettype none
// ============================================================================
// nrzi_crc_rx : NRZI line receiver, LSB-first payload + MSB-first CRC check
// Revision    : 1.0
// ============================================================================
module nrzi_crc_rx
    import crc_nrzi_pkg::*;
#(
    parameter int               DATA_W   = DATA_W_DEF,
    parameter int               CRC_W    = CRC_W_DEF,
    parameter logic [CRC_W-1:0] POLY     = CRC_W'(POLY_DEF),
    parameter logic [CRC_W-1:0] CRC_INIT = CRC_W'(CRC_INIT_DEF)
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              y_i,
    input  logic              en_i,
    input  logic              sof_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              crc_ok_o,
    output logic              crc_err_o,
    output logic              abort_o
);

    localparam int               CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC_W - 1);

    rx_state_e         r_state, state_n;
    logic [CNT_W-1:0]  r_cnt, cnt_n;
    logic [CRC_W-1:0]  r_crc, crc_n;
    logic [DATA_W-1:0] r_shift, shift_n;
    logic [DATA_W-1:0] r_data, data_n;
    logic              r_ok, ok_n;
    logic              r_valid, valid_n;
    logic              r_abort, abort_n;
    logic              w_d;
    logic [CRC_W-1:0]  w_crc_stepped;
    logic [CRC_W-1:0]  w_crc_seeded;

    nrzi_dec u_nrzi_dec (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .en_i     (en_i),
        .y_i      (y_i),
        .d_o      (w_d)
    );

    assign w_crc_stepped = CRC_W'(crc_step(CRC_MAX'(r_crc), w_d, CRC_MAX'(POLY), CRC_W));
    assign w_crc_seeded  = CRC_W'(crc_step(CRC_MAX'(CRC_INIT), w_d, CRC_MAX'(POLY), CRC_W));

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_crc   <= CRC_INIT;
            r_shift <= '0;
            r_data  <= '0;
            r_ok    <= 1'b0;
            r_valid <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= state_n;
            r_cnt   <= cnt_n;
            r_crc   <= crc_n;
            r_shift <= shift_n;
            r_data  <= data_n;
            r_ok    <= ok_n;
            r_valid <= valid_n;
            r_abort <= abort_n;
        end
    end

    always_comb begin
        state_n = r_state;
        cnt_n   = r_cnt;
        crc_n   = r_crc;
        shift_n = r_shift;
        data_n  = r_data;
        ok_n    = r_ok;
        valid_n = 1'b0;
        abort_n = 1'b0;
        // DONE is a single-cycle verdict state, even when no bit arrives.
        if (r_state == DONE) begin
            state_n = IDLE;
        end
        if (en_i) begin
            if (sof_i) begin
                state_n = DATA;
                cnt_n   = CNT_W'(1);
                crc_n   = w_crc_seeded;
                shift_n = DATA_W'(w_d);
                abort_n = (r_state == DATA) || (r_state == CHECK);
            end else begin
                case (r_state)
                    DATA: begin
                        shift_n[r_cnt] = w_d;
                        crc_n          = w_crc_stepped;
                        if (r_cnt == LAST_DATA) begin
                            state_n = CHECK;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = r_cnt + CNT_W'(1);
                        end
                    end
                    CHECK: begin
                        crc_n = w_crc_stepped;
                        if (r_cnt == LAST_CRC) begin
                            state_n = DONE;
                            cnt_n   = '0;
                            valid_n = 1'b1;
                            data_n  = r_shift;
                            ok_n    = (w_crc_stepped == '0);
                        end else begin
                            cnt_n = r_cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_o       = r_data;
    assign data_valid_o = r_valid;
    assign crc_ok_o     = r_ok;
    assign crc_err_o    = r_valid & ~r_ok;
    assign abort_o      = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_nrzi_crc_rx.sv
`default_nettype none
// ============================================================================
// tb_nrzi_crc_rx : directed self-checking bench for nrzi_crc_rx
// Revision       : 1.0
// ============================================================================
module tb_nrzi_crc_rx;
    import crc_nrzi_pkg::*;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        y      = 1'b0;
    logic        en     = 1'b0;
    logic        sof    = 1'b0;
    logic [31:0] data;
    logic        valid, ok, err, abrt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_valid  = 0;
    int   n_abort  = 0;
    logic line     = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) n_valid <= n_valid + 1;
        if (abrt)  n_abort <= n_abort + 1;
    end

    nrzi_crc_rx dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .y_i          (y),
        .en_i         (en),
        .sof_i        (sof),
        .data_o       (data),
        .data_valid_o (valid),
        .crc_ok_o     (ok),
        .crc_err_o    (err),
        .abort_o      (abrt)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Serial NRZ stream: payload LSB first, then CRC MSB first.
    function automatic logic [47:0] make_frame(input logic [31:0] p);
        logic [15:0] c;
        logic [47:0] f;
        c = CRC_INIT_DEF;
        for (int i = 0; i < 32; i++) begin
            f[i] = p[i];
            c    = 16'(crc_step(32'(c), p[i], 32'(POLY_DEF), 16));
        end
        for (int j = 0; j < 16; j++) f[32+j] = c[15-j];
        return f;
    endfunction

    task automatic drive_bit(input logic b, input logic s, input logic flip, input int gap);
        repeat (gap) begin
            en = 1'b0; sof = 1'b0;
            @(posedge clk); #1;
        end
        if (b) line = ~line;
        en  = 1'b1;
        sof = s;
        y   = line ^ flip;
        @(posedge clk); #1;
        en  = 1'b0;
        sof = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] f, input int first, input int last,
                              input int gap, input int flip_idx);
        for (int i = first; i <= last; i++)
            drive_bit(f[i], (i == 0), (i == flip_idx), gap);
    endtask

    task automatic test_reset;
        resetn = 1'b0; en = 1'b0; sof = 1'b0; y = 1'b0; line = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL reset data_o: got %h expected %h", data, 32'h0); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset data_valid_o: got %b expected 0", valid); end
        n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL reset crc_ok_o: got %b expected 0", ok); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset crc_err_o: got %b expected 0", err); end
        n_checks++; if (abrt !== 1'b0) begin n_fail++; $display("FAIL reset abort_o: got %b expected 0", abrt); end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_frame;
        int v0;
        v0 = n_valid;
        send_frame(48'h0, 0, 46, 0, -1);
        n_checks++; if (n_valid != v0 || valid !== 1'b0) begin n_fail++; $display("FAIL zero early valid: got %0d pulses expected 0", n_valid - v0); end
        send_frame(48'h0, 47, 47, 0, -1);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL zero data_valid_o: got %b expected 1", valid); end
        n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL zero data_o: got %h expected %h", data, 32'h0); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero crc_ok_o: got %b expected 1", ok); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero crc_err_o: got %b expected 0", err); end
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL zero valid pulse width: got %b expected 0", valid); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero crc_ok_o hold: got %b expected 1", ok); end
    endtask

    task automatic test_payload;
        logic [47:0] f;
        f = make_frame(32'hA5A55A5A);
        for (int g = 0; g <= 2; g += 2) begin
            send_frame(f, 0, 47, g, -1);
            n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL payload gap%0d data_valid_o: got %b expected 1", g, valid); end
            n_checks++; if (data !== 32'hA5A55A5A) begin n_fail++; $display("FAIL payload gap%0d data_o: got %h expected %h", g, data, 32'hA5A55A5A); end
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL payload gap%0d crc_ok_o: got %b expected 1", g, ok); end
            n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL payload gap%0d crc_err_o: got %b expected 0", g, err); end
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_bit_error;
        logic [47:0] f;
        f = make_frame(32'hA5A55A5A);
        send_frame(f, 0, 47, 0, 10);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL biterr data_valid_o: got %b expected 1", valid); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL biterr crc_err_o: got %b expected 1", err); end
        n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL biterr crc_ok_o: got %b expected 0", ok); end
        n_checks++; if (data !== 32'hA5A5565A) begin n_fail++; $display("FAIL biterr data_o: got %h expected %h", data, 32'hA5A5565A); end
        @(posedge clk); #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL biterr crc_err_o pulse width: got %b expected 0", err); end
        n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL biterr crc_ok_o hold: got %b expected 0", ok); end
    endtask

    task automatic test_back_to_back;
        logic [47:0] f1, f2;
        int v0, c1, c2;
        f1 = make_frame(32'hA5A55A5A);
        f2 = make_frame(32'hDEADBEEF);
        v0 = n_valid;
        send_frame(f1, 0, 47, 0, -1);
        c1 = cyc;
        n_checks++; if (valid !== 1'b1 || ok !== 1'b1 || data !== 32'hA5A55A5A) begin n_fail++; $display("FAIL b2b first frame: got valid=%b ok=%b data=%h expected 1 1 %h", valid, ok, data, 32'hA5A55A5A); end
        send_frame(f2, 0, 47, 0, -1);
        c2 = cyc;
        n_checks++; if (valid !== 1'b1 || ok !== 1'b1) begin n_fail++; $display("FAIL b2b second verdict: got valid=%b ok=%b expected 1 1", valid, ok); end
        n_checks++; if (data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b second data_o: got %h expected %h", data, 32'hDEADBEEF); end
        n_checks++; if (c2 - c1 != 48) begin n_fail++; $display("FAIL b2b pulse spacing: got %0d expected 48", c2 - c1); end
        @(posedge clk); #1;
        n_checks++; if (n_valid - v0 != 2) begin n_fail++; $display("FAIL b2b pulse count: got %0d expected 2", n_valid - v0); end
    endtask

    task automatic test_abort;
        logic [47:0] fx, fy;
        int v0, a0;
        fx = make_frame(32'h0F0F1234);
        fy = make_frame(32'hCAFEF00D);
        v0 = n_valid;
        a0 = n_abort;
        send_frame(fx, 0, 19, 0, -1);
        send_frame(fy, 0, 0, 0, -1);
        n_checks++; if (abrt !== 1'b1) begin n_fail++; $display("FAIL abort abort_o: got %b expected 1", abrt); end
        n_checks++; if (data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL abort data_o kept: got %h expected %h", data, 32'hDEADBEEF); end
        send_frame(fy, 1, 46, 0, -1);
        n_checks++; if (n_abort - a0 != 1) begin n_fail++; $display("FAIL abort pulse count: got %0d expected 1", n_abort - a0); end
        n_checks++; if (n_valid != v0 || data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL abort early valid: got %0d pulses data=%h expected 0 %h", n_valid - v0, data, 32'hDEADBEEF); end
        send_frame(fy, 47, 47, 0, -1);
        n_checks++; if (valid !== 1'b1 || ok !== 1'b1) begin n_fail++; $display("FAIL abort new frame verdict: got valid=%b ok=%b expected 1 1", valid, ok); end
        n_checks++; if (data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL abort new frame data_o: got %h expected %h", data, 32'hCAFEF00D); end
    endtask

    task automatic test_reset_mid;
        logic [47:0] fz, fw;
        int v0;
        fz = make_frame(32'h13572468);
        fw = make_frame(32'h89ABCDEF);
        @(posedge clk); #1;
        v0 = n_valid;
        send_frame(fz, 0, 36, 0, -1);
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (data !== 32'h0 || ok !== 1'b0 || valid !== 1'b0 || err !== 1'b0 || abrt !== 1'b0) begin n_fail++; $display("FAIL midreset async outputs: got data=%h ok=%b valid=%b err=%b abort=%b expected all 0", data, ok, valid, err, abrt); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (data !== 32'h0 || ok !== 1'b0) begin n_fail++; $display("FAIL midreset held outputs: got data=%h ok=%b expected 0 0", data, ok); end
        resetn = 1'b1;
        line = 1'b0;
        y = 1'b0;
        @(posedge clk); #1;
        send_frame(fz, 37, 47, 0, -1);
        @(posedge clk); #1;
        n_checks++; if (n_valid != v0 || valid !== 1'b0) begin n_fail++; $display("FAIL midreset stale pulse: got %0d pulses expected 0", n_valid - v0); end
        send_frame(fw, 0, 47, 0, -1);
        n_checks++; if (valid !== 1'b1 || ok !== 1'b1) begin n_fail++; $display("FAIL midreset next verdict: got valid=%b ok=%b expected 1 1", valid, ok); end
        n_checks++; if (data !== 32'h89ABCDEF) begin n_fail++; $display("FAIL midreset next data_o: got %h expected %h", data, 32'h89ABCDEF); end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_payload();
        test_bit_error();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nrzi_crc_rx.md
Name: nrzi_crc_rx

Overview:
Receive-side counterpart of the CRC+NRZI serial transmitter. It takes the NRZI line one bit per qualified clock and decodes it to NRZ. It collects DATA_W payload bits LSB-first, then CRC_W check bits MSB-first. It presents the recovered word with a CRC pass/fail verdict. It sits at the serial line input, ahead of word-level consumers.

Parameters:
DATA_W, 32, payload bits per frame
CRC_W, 16, CRC width
POLY, 16'h8005, CRC generator polynomial (implicit x^CRC_W term)
CRC_INIT, 16'h0000, LFSR seed loaded at frame start

Ports:
clk_i  in  1  clock, all logic on rising edge
resetn_i  in  1  reset; one clock, asynchronous assert, active-low
y_i  in  1  NRZI line bit, sampled when en_i=1
en_i  in  1  bit-valid strobe; one line bit is consumed per cycle with en_i=1
sof_i  in  1  first bit of a frame; qualified by en_i
data_o  out  DATA_W  last completed payload word
data_valid_o  out  1  one-cycle pulse, frame complete
crc_ok_o  out  1  CRC verdict of the last frame; valid with and after data_valid_o
crc_err_o  out  1  one-cycle pulse, completed frame failed CRC
abort_o  out  1  one-cycle pulse, frame restarted by sof_i mid-frame

Behaviour:
- Reset values: prev_line=0, state=IDLE, bit_cnt=0, crc=CRC_INIT, and data_o, data_valid_o, crc_ok_o, crc_err_o, abort_o all 0.
- NRZI decode (transition = 1):
  - Decoded bit d = y_i ^ prev_line.
  - prev_line <= y_i on every en_i=1 cycle, in all states, including IDLE.
  - en_i=0 cycles change no state at all.
- CRC step per accepted bit:
  - fb = crc[CRC_W-1] ^ d
  - crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
  - The whole DATA_W+CRC_W bit stream is fed through the LFSR. A final remainder of 0 means pass. There is no final XOR.
- FSM states:
  - IDLE: on en_i&sof_i, treat the bit as payload bit 0 and go to DATA. The CRC step uses the seed CRC_INIT.
  - DATA: shift d into payload register position bit_cnt (LSB first). After bit DATA_W-1, go to CHECK with bit_cnt=0.
  - CHECK: feed CRC_W bits into the LFSR only. On the last bit, go to DONE.
  - DONE: lasts one cycle. It outputs the verdict, then returns to IDLE. If en_i&sof_i arrives in DONE, it starts a new frame (same as IDLE), so back-to-back frames lose no bits.
- Output timing:
  - data_valid_o pulses exactly 1 cycle after the last CRC bit is sampled.
  - In that same cycle, data_o and crc_ok_o update (registered).
  - crc_err_o = data_valid_o & ~crc_ok_o.
  - data_o and crc_ok_o hold until the next completed frame.
- sof_i mid-frame (DATA or CHECK with en_i=1):
  - Pulse abort_o the next cycle.
  - Discard the partial frame, reseed crc, and treat the current bit as bit 0 of a new frame.
  - data_o and crc_ok_o are unchanged.
- sof_i in IDLE without en_i is ignored.
- en_i=1 without sof_i in IDLE: only prev_line tracks the line.
- Asynchronous reset mid-frame: everything returns to reset values immediately and the frame is lost. No pulse is generated.
- bit_cnt width is $clog2(DATA_W). It must not wrap inside DATA/CHECK, since terminal counts are compared explicitly.

Decomposition:
- Package crc_nrzi_pkg holds:
  - rx_state_e enum {IDLE, DATA, CHECK, DONE}
  - default DATA_W/CRC_W/POLY/CRC_INIT constants, shared with the transmitter
  - function crc_step(crc, bit) for the RTL and the bench model
- One sub-module, nrzi_dec: holds prev_line and produces d. Instantiated once.

Test Plan:
- Reset, then an all-zero frame: line held 0 for 48 en_i cycles with sof_i on the first → data_valid_o at cycle 49, data_o=32'h0, crc_ok_o=1, crc_err_o=0.
- Payload 32'hA5A5_5A5A: NRZI-encode the payload plus the crc_step-computed CRC and drive it → data_o=32'hA5A55A5A, crc_ok_o=1. Repeat with en_i gapped (1 of every 3 cycles) → identical result.
- Same frame with line bit 10 inverted → data_valid_o pulse, crc_err_o=1, crc_ok_o=0.
- Two frames back-to-back, with the second sof_i in the DONE cycle → two data_valid_o pulses 48 en_i cycles apart, both crc_ok_o=1, second data_o=32'hDEADBEEF.
- sof_i at payload bit 20, then a full valid frame → abort_o pulse 1 cycle later, and data_o unchanged until the new frame completes with crc_ok_o=1.
- resetn_i low at CRC bit 5, then a new frame → no data_valid_o from the broken frame, all outputs 0 during reset, and the following frame decodes correctly.
